// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one instruction-memory request
// outstanding at a time, and owns the IF/ID pipeline register. Handles
// stall, flush and branch redirect, and discards fetches made stale by a
// redirect while they were still in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_en,
  input  logic        fd_en,
  input  logic        fd_stall,
  input  logic        fd_flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_IF_ID,
  output logic [31:0] inst_IF_ID,
  output logic        valid_IF_ID
);

  // FETCH: request pc; KILL: request still in flight but its data is stale;
  // HOLD: no request, one fetched instruction parked in the buffer.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_KILL  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] buf_inst_q, buf_inst_d;

  logic        accept;
  logic        xfer;
  logic [31:0] tgt_pc;
  logic        deliver;
  logic [31:0] dlv_inst;

  assign accept = pc_en & fd_en & ~fd_stall;
  assign xfer   = imem_req & imem_ack;
  // Low address bits of a redirect target are ignored so fetches stay word aligned.
  assign tgt_pc = redirect_pc & 32'hFFFF_FFFC;

  // State register: control state, PC and the IF/ID register (reset values apply)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      pc_IF_ID    <= 32'h0000_0000;
      inst_IF_ID  <= NOP_INST;
      valid_IF_ID <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (fd_flush && fd_en) begin
        pc_IF_ID    <= 32'h0000_0000;
        inst_IF_ID  <= NOP_INST;
        valid_IF_ID <= 1'b0;
      end else if (fd_stall || !fd_en) begin
        pc_IF_ID    <= pc_IF_ID;
        inst_IF_ID  <= inst_IF_ID;
        valid_IF_ID <= valid_IF_ID;
      end else if (deliver) begin
        pc_IF_ID    <= pc_q;
        inst_IF_ID  <= dlv_inst;
        valid_IF_ID <= 1'b1;
      end else begin
        inst_IF_ID  <= NOP_INST;
        valid_IF_ID <= 1'b0;
      end
    end
  end

  // Datapath holding registers: only meaningful in KILL/HOLD, so no reset
  always_ff @(posedge clk) begin
    redir_q    <= redir_d;
    buf_inst_q <= buf_inst_d;
  end

  // Next-state logic: fetch FSM transitions, PC update and delivery decision
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redir_d    = redir_q;
    buf_inst_d = buf_inst_q;
    deliver    = 1'b0;
    dlv_inst   = imem_rdata;
    case (state_q)
      S_FETCH: begin
        if (xfer) begin
          if (redirect_valid) begin
            pc_d = tgt_pc;
          end else if (accept) begin
            deliver = 1'b1;
            pc_d    = pc_q + 32'd4;
          end else begin
            // The buffered instruction's pc is pc_q, which does not move in HOLD.
            buf_inst_d = imem_rdata;
            state_d    = S_HOLD;
          end
        end else if (redirect_valid) begin
          // Address must stay put until the ack; remember where to go next.
          redir_d = tgt_pc;
          state_d = S_KILL;
        end
      end
      S_KILL: begin
        if (redirect_valid) begin
          redir_d = tgt_pc;
        end
        if (xfer) begin
          pc_d    = redirect_valid ? tgt_pc : redir_q;
          state_d = S_FETCH;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = tgt_pc;
          state_d = S_FETCH;
        end else if (accept) begin
          deliver  = 1'b1;
          dlv_inst = buf_inst_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Output logic: request while fetching or killing, never during reset
  always_comb begin
    imem_req  = rst_n && (state_q != S_HOLD);
    imem_addr = pc_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: instruction memory returns ~addr as data.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_en;
  logic        fd_en;
  logic        fd_stall;
  logic        fd_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_IF_ID;
  logic [31:0] inst_IF_ID;
  logic        valid_IF_ID;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_rdata = ~imem_addr;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0013)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_en         (pc_en),
    .fd_en         (fd_en),
    .fd_stall      (fd_stall),
    .fd_flush      (fd_flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .pc_IF_ID      (pc_IF_ID),
    .inst_IF_ID    (inst_IF_ID),
    .valid_IF_ID   (valid_IF_ID)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; pc_en = 1'b1; fd_en = 1'b1; fd_stall = 1'b0; fd_flush = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; imem_ack = 1'b1;

    // 1: reset, then streaming fetch with immediate ack
    #1;
    check("req_in_reset", {31'b0, imem_req}, 32'h0);
    tick();
    check("rst_valid", {31'b0, valid_IF_ID}, 32'h0);
    check("rst_inst", inst_IF_ID, 32'h0000_0013);
    check("rst_pc", pc_IF_ID, 32'h0);
    rst_n = 1'b1; #1;
    check("t1_req", {31'b0, imem_req}, 32'h1);
    check("t1_addr0", imem_addr, 32'h0);
    tick();
    check("t1_addr4", imem_addr, 32'h4);
    check("t1_valid", {31'b0, valid_IF_ID}, 32'h1);
    check("t1_pc0", pc_IF_ID, 32'h0);
    check("t1_inst0", inst_IF_ID, 32'hFFFF_FFFF);
    tick();
    check("t1_addr8", imem_addr, 32'h8);
    check("t1_pc4", pc_IF_ID, 32'h4);
    tick();
    check("t1_addrC", imem_addr, 32'hC);
    check("t1_pc8", pc_IF_ID, 32'h8);
    check("t1_inst8", inst_IF_ID, 32'hFFFF_FFF7);

    // 2: redirect while request outstanding -> KILL, data dropped
    rst_n = 1'b0; imem_ack = 1'b0;
    tick();
    rst_n = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    check("t2_addr_c0", imem_addr, 32'h0);
    tick();
    redirect_valid = 1'b0; #1;
    check("t2_addr_c1", imem_addr, 32'h0);
    check("t2_req_c1", {31'b0, imem_req}, 32'h1);
    tick();
    check("t2_addr_c2", imem_addr, 32'h0);
    imem_ack = 1'b1; #1;
    check("t2_addr_ack", imem_addr, 32'h0);
    tick();
    check("t2_valid", {31'b0, valid_IF_ID}, 32'h0);
    check("t2_next_addr", imem_addr, 32'h100);

    // 3: ack under stall parks the instruction; released exactly once
    tick();
    check("t3_pre_pc", pc_IF_ID, 32'h100);
    check("t3_pre_inst", inst_IF_ID, 32'hFFFF_FEFF);
    fd_stall = 1'b1; pc_en = 1'b0;
    tick();
    check("t3_hold_req", {31'b0, imem_req}, 32'h0);
    check("t3_hold_valid", {31'b0, valid_IF_ID}, 32'h1);
    check("t3_hold_pc", pc_IF_ID, 32'h100);
    tick();
    check("t3_hold_req2", {31'b0, imem_req}, 32'h0);
    check("t3_hold_inst2", inst_IF_ID, 32'hFFFF_FEFF);
    fd_stall = 1'b0; pc_en = 1'b1;
    tick();
    check("t3_rel_valid", {31'b0, valid_IF_ID}, 32'h1);
    check("t3_rel_pc", pc_IF_ID, 32'h104);
    check("t3_rel_inst", inst_IF_ID, 32'hFFFF_FEFB);
    check("t3_rel_addr", imem_addr, 32'h108);
    imem_ack = 1'b0;
    tick();
    check("t3_once_valid", {31'b0, valid_IF_ID}, 32'h0);
    check("t3_once_inst", inst_IF_ID, 32'h0000_0013);
    check("t3_once_pc", pc_IF_ID, 32'h104);

    // 4: flush + redirect on the ack of 0x8
    imem_ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h4;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("t4_pre_valid", {31'b0, valid_IF_ID}, 32'h1);
    check("t4_pre_pc", pc_IF_ID, 32'h4);
    fd_flush = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    check("t4_ack_addr", imem_addr, 32'h8);
    tick();
    fd_flush = 1'b0; redirect_valid = 1'b0;
    check("t4_valid", {31'b0, valid_IF_ID}, 32'h0);
    check("t4_inst", inst_IF_ID, 32'h0000_0013);
    check("t4_pc", pc_IF_ID, 32'h0);
    check("t4_addr", imem_addr, 32'h40);

    // 5: redirect out of HOLD (unaligned target, pc_en low)
    fd_stall = 1'b1; pc_en = 1'b0;
    tick();
    check("t5_hold_req", {31'b0, imem_req}, 32'h0);
    fd_stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h83;
    tick();
    redirect_valid = 1'b0; pc_en = 1'b1;
    check("t5_valid", {31'b0, valid_IF_ID}, 32'h0);
    check("t5_addr", imem_addr, 32'h80);
    check("t5_req", {31'b0, imem_req}, 32'h1);

    // 6: reset mid-request, then PC wrap
    tick();
    check("t6_dlv_pc", pc_IF_ID, 32'h80);
    imem_ack = 1'b0; fd_stall = 1'b1;
    tick();
    check("t6_out_valid", {31'b0, valid_IF_ID}, 32'h1);
    check("t6_out_addr", imem_addr, 32'h84);
    rst_n = 1'b0; #1;
    check("t6_req_rst", {31'b0, imem_req}, 32'h0);
    tick();
    check("t6_rst_valid", {31'b0, valid_IF_ID}, 32'h0);
    check("t6_rst_inst", inst_IF_ID, 32'h0000_0013);
    rst_n = 1'b1; fd_stall = 1'b0; #1;
    check("t6_rst_addr", imem_addr, 32'h0);
    check("t6_rst_req", {31'b0, imem_req}, 32'h1);
    imem_ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check("t6_wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("t6_wrap_next", imem_addr, 32'h0);
    check("t6_wrap_pc", pc_IF_ID, 32'hFFFF_FFFC);
    check("t6_wrap_inst", inst_IF_ID, 32'h0000_0003);
    check("t6_wrap_valid", {31'b0, valid_IF_ID}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
